// File: rtl/br_resolve_if.sv
// Redirect channel from the branch resolution stage to fetch.
//
// Handshake: the master raises redirect_valid_o with redirect_pc_o and keeps
// both stable until a cycle where redirect_ready_i=1 is seen at the rising
// clock edge; that edge completes the transfer. The slave may drive
// redirect_ready_i independently of redirect_valid_o.
interface br_resolve_if;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  modport master (
    output redirect_valid_o,
    output redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  redirect_valid_o,
    input  redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/br_resolve.sv
// Branch resolution stage: decodes taken/not-taken from funct3 and the
// comparator flags, issues a registered redirect to fetch, then holds
// flush/stall for a fixed number of cycles while younger work is squashed.
// Also keeps counters of accepted branches and issued redirects.
module br_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             br_valid_i,
  input  logic             br_jump_i,
  input  logic [2:0]       br_funct3_i,
  input  logic             br_equal_i,
  input  logic             br_less_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      br_target_i,
  output logic             br_unsigned_o,
  output logic             br_taken_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             misalign_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] taken_count_o,
  output logic [1:0]       dbg_state_o,
  br_resolve_if.master     redir
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] redirect_pc_q;
  logic        cond_taken;
  logic        accept;
  logic        taken;
  logic        illegal_f3;
  logic        target_misaligned;
  logic        go_redirect;
  logic        go_misalign;

  // The PC of the branch is not needed here; the target arrives precomputed.
  logic        unused_pc;
  assign unused_pc = ^pc_i;

  // funct3[1] selects unsigned compare for BLTU/BGEU.
  assign br_unsigned_o = br_funct3_i[1];

  // Conditional-branch taken decode from funct3 and comparator flags.
  always_comb begin
    cond_taken = 1'b0;
    case (br_funct3_i)
      3'b000:  cond_taken = br_equal_i;
      3'b001:  cond_taken = !br_equal_i;
      3'b100:  cond_taken = br_less_i;
      3'b101:  cond_taken = !br_less_i;
      3'b110:  cond_taken = br_less_i;
      3'b111:  cond_taken = !br_less_i;
      default: cond_taken = 1'b0;
    endcase
  end

  // New branches are only taken in while idle; otherwise upstream is stalled.
  assign accept            = (state_q == IDLE) && (br_valid_i || br_jump_i);
  assign taken             = br_jump_i || cond_taken;
  assign illegal_f3        = !br_jump_i && (br_funct3_i[2:1] == 2'b01);
  assign target_misaligned = (br_target_i[1:0] != 2'b00);
  assign go_redirect       = accept && taken && !target_misaligned;
  assign go_misalign       = accept && taken && target_misaligned;

  // Next-state logic: redirect until fetch accepts, then count down the flush.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (go_redirect) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redir.redirect_ready_i) begin
          state_d     = FLUSH;
          flush_cnt_d = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = IDLE;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and flush countdown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Registered result pulses, redirect target capture and statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_taken_o    <= 1'b0;
      misalign_o    <= 1'b0;
      illegal_o     <= 1'b0;
      redirect_pc_q <= 32'd0;
      br_count_o    <= '0;
      taken_count_o <= '0;
    end else begin
      br_taken_o <= go_redirect;
      misalign_o <= go_misalign;
      illegal_o  <= accept && illegal_f3;
      if (go_redirect) begin
        redirect_pc_q <= br_target_i;
        taken_count_o <= taken_count_o + CNT_W'(1);
      end
      if (accept) br_count_o <= br_count_o + CNT_W'(1);
    end
  end

  assign redir.redirect_valid_o = (state_q == REDIRECT);
  assign redir.redirect_pc_o    = redirect_pc_q;
  assign flush_o                = (state_q != IDLE);
  assign stall_o                = (state_q != IDLE);
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed scenarios followed by random branches.
// Expected responses come from a small instruction-level model and are
// queued by the driver; a negedge monitor pops and compares them.
module tb_br_resolve;
  localparam int FC = 2;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          br_valid_i, br_jump_i, br_equal_i, br_less_i;
  logic [2:0]    br_funct3_i;
  logic [31:0]   pc_i, br_target_i;
  logic          br_unsigned_o, br_taken_o, flush_o, stall_o, misalign_o, illegal_o;
  logic [CW-1:0] br_count_o, taken_count_o;
  logic [1:0]    dbg_state_o;

  br_resolve_if rif ();

  br_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .br_valid_i    (br_valid_i),
    .br_jump_i     (br_jump_i),
    .br_funct3_i   (br_funct3_i),
    .br_equal_i    (br_equal_i),
    .br_less_i     (br_less_i),
    .pc_i          (pc_i),
    .br_target_i   (br_target_i),
    .br_unsigned_o (br_unsigned_o),
    .br_taken_o    (br_taken_o),
    .flush_o       (flush_o),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o),
    .illegal_o     (illegal_o),
    .br_count_o    (br_count_o),
    .taken_count_o (taken_count_o),
    .dbg_state_o   (dbg_state_o),
    .redir         (rif.master)
  );

  // ---------------- scoreboard ----------------
  // Record per accepted branch: {taken, misalign, illegal, br_count, taken_count}
  logic [10:0] exp_q[$];
  logic [31:0] redir_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int m_bc = 0;
  int m_tc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Architectural branch outcome, straight from the funct3 table.
  function automatic logic ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic garbage();
    br_valid_i  = 1'($urandom_range(0, 1));
    br_jump_i   = 1'($urandom_range(0, 1));
    br_funct3_i = 3'($urandom_range(0, 7));
    br_target_i = $urandom;
  endtask

  task automatic drive_branch(input logic v, input logic j, input logic [2:0] f3,
                              input logic eq, input logic lt, input logic [31:0] tgt,
                              input int rdy_delay, input bit hold);
    logic acc, tk, ill, mis, red;
    br_valid_i  = v;
    br_jump_i   = j;
    br_funct3_i = f3;
    br_equal_i  = eq;
    br_less_i   = lt;
    br_target_i = tgt;
    pc_i        = $urandom;
    rif.redirect_ready_i = 1'b0;
    acc = v || j;
    tk  = j ? 1'b1 : ref_taken(f3, eq, lt);
    ill = !j && v && (f3 == 3'b010 || f3 == 3'b011);
    mis = acc && tk && (tgt % 4 != 0);
    red = acc && tk && !mis;
    if (acc) begin
      m_bc = (m_bc + 1) % (1 << CW);
      if (red) begin
        m_tc = (m_tc + 1) % (1 << CW);
        redir_q.push_back(tgt);
      end
      exp_q.push_back({red, mis, ill, 4'(m_bc), 4'(m_tc)});
    end
    step();
    br_valid_i = 1'b0;
    br_jump_i  = 1'b0;
    if (red && !hold) begin
      // Redirect pending: inputs offered now must be ignored by the stage.
      for (int i = 0; i < rdy_delay; i++) begin
        garbage();
        rif.redirect_ready_i = 1'b0;
        step();
      end
      garbage();
      rif.redirect_ready_i = 1'b1;
      step();
      for (int i = 0; i < FC; i++) begin
        garbage();
        rif.redirect_ready_i = 1'($urandom_range(0, 1));
        step();
      end
      br_valid_i = 1'b0;
      br_jump_i  = 1'b0;
      rif.redirect_ready_i = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  logic [CW-1:0] prev_bc;
  logic          prev_v, prev_r;
  logic [31:0]   prev_pc;
  bit            measuring;
  int            run;

  initial begin
    logic [10:0] e;
    prev_bc = '0; prev_v = 1'b0; prev_r = 1'b0; prev_pc = '0; measuring = 0; run = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_bc = '0; prev_v = 1'b0; prev_r = 1'b0; measuring = 0;
      end else begin
        chk("stall_eq_flush", stall_o, flush_o);
        chk("br_unsigned", br_unsigned_o, br_funct3_i[1]);
        if (rif.redirect_valid_o) chk("flush_in_redirect", flush_o, 1);
        if (rif.redirect_valid_o && prev_v && !prev_r)
          chk("redirect_pc_stable", rif.redirect_pc_o, prev_pc);
        if (!rif.redirect_valid_o && !measuring) chk("no_spurious_flush", flush_o, 0);
        if (br_taken_o || misalign_o || illegal_o || (br_count_o != prev_bc)) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_response: actual taken=%0b mis=%0b ill=%0b bc=%0d required none",
                     br_taken_o, misalign_o, illegal_o, br_count_o);
          end else begin
            e = exp_q.pop_front();
            chk("br_taken", br_taken_o, e[10]);
            chk("misalign", misalign_o, e[9]);
            chk("illegal", illegal_o, e[8]);
            chk("br_count", br_count_o, e[7:4]);
            chk("taken_count", taken_count_o, e[3:0]);
          end
        end
        if (measuring) begin
          if (flush_o) begin
            run++;
            if (run > FC + 4) begin
              chk("flush_len_bound", run, FC);
              measuring = 0;
            end
          end else begin
            chk("flush_len", run, FC);
            measuring = 0;
          end
        end
        if (rif.redirect_valid_o && rif.redirect_ready_i) begin
          if (redir_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_redirect: actual pc=0x%0h required none", rif.redirect_pc_o);
          end else begin
            chk("redirect_pc", rif.redirect_pc_o, redir_q.pop_front());
          end
          measuring = 1;
          run = 0;
        end
        prev_bc = br_count_o;
        prev_v  = rif.redirect_valid_o;
        prev_r  = rif.redirect_ready_i;
        prev_pc = rif.redirect_pc_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic [1:0]  lo;
    rst_ni = 1'b0;
    br_valid_i = 0; br_jump_i = 0; br_funct3_i = 0; br_equal_i = 0; br_less_i = 0;
    pc_i = 0; br_target_i = 0; rif.redirect_ready_i = 0;
    #3;
    chk("rst_redirect_valid", rif.redirect_valid_o, 0);
    chk("rst_redirect_pc", rif.redirect_pc_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_br_count", br_count_o, 0);
    chk("rst_taken_count", taken_count_o, 0);
    chk("rst_state", dbg_state_o, 0);
    step(); step();
    rst_ni = 1'b1;
    step();

    // BEQ taken, fetch ready immediately.
    drive_branch(1, 0, 3'b000, 1, 0, 32'h0000_0100, 0, 0);
    // BLTU taken with three cycles of backpressure.
    drive_branch(1, 0, 3'b110, 0, 1, 32'h0000_2000, 3, 0);
    // Not-taken BNE stream, back to back.
    for (int i = 0; i < 4; i++) drive_branch(1, 0, 3'b001, 1, 0, 32'h40 + 32'(i * 4), 0, 0);
    // Illegal funct3 and misaligned jump.
    drive_branch(1, 0, 3'b010, 1, 1, 32'h0000_0300, 0, 0);
    drive_branch(0, 1, 3'b000, 0, 0, 32'h0000_0102, 0, 0);
    step();
    // Sixteen taken jumps wrap the 4-bit taken counter.
    for (int i = 0; i < 16; i++)
      drive_branch(0, 1, 3'($urandom_range(0, 7)), 0, 0, 32'h1000 + 32'(i * 4), 0, 0);
    chk("wrap_taken_count", taken_count_o, 4'(m_tc));

    // Reset while a redirect is pending.
    drive_branch(0, 1, 3'b000, 0, 0, 32'h0000_0800, 0, 1);
    step();
    chk("pre_reset_redirect_valid", rif.redirect_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_redirect_valid", rif.redirect_valid_o, 0);
    chk("midrst_flush", flush_o, 0);
    chk("midrst_br_count", br_count_o, 0);
    chk("midrst_taken_count", taken_count_o, 0);
    exp_q.delete();
    redir_q.delete();
    m_bc = 0;
    m_tc = 0;
    step();
    rst_ni = 1'b1;
    step();
    chk("post_reset_state", dbg_state_o, 0);

    // Random branches.
    for (int i = 0; i < 150; i++) begin
      r  = $urandom;
      lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive_branch(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), {r[31:2], lo}, $urandom_range(0, 3), 0);
    end

    step(); step(); step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("redir_q_drained", redir_q.size(), 0);
    chk("flush_measure_done", measuring, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Branch resolution stage directly downstream of the branch comparator in the RV32I core.
- Consumes br_equal/br_less and drives br_unsigned back to the comparator.
- Decides taken/not-taken from funct3 and issues a registered redirect to fetch using a valid/ready handshake.
- Holds flush/stall while younger instructions are squashed, and keeps branch statistics counters.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after the redirect handshake completes; legal range 1..15.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- br_valid_i  in  1  conditional branch present in this stage this cycle
- br_jump_i  in  1  unconditional jump (JAL/JALR); always taken, funct3 ignored
- br_funct3_i  in  3  branch funct3 field
- br_equal_i  in  1  from comparator: rs1 == rs2
- br_less_i  in  1  from comparator: rs1 < rs2, signed or unsigned per br_unsigned_o
- pc_i  in  32  PC of the branch
- br_target_i  in  32  computed target address
- br_unsigned_o  out  1  to comparator; combinational = br_funct3_i[1]
- br_taken_o  out  1  registered one-cycle pulse: accepted branch resolved taken
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target; held stable while redirect_valid_o=1
- redirect_ready_i  in  1  fetch accepts the redirect
- flush_o  out  1  squash younger pipeline stages
- stall_o  out  1  upstream must hold its branch; equals flush_o
- misalign_o  out  1  registered pulse: taken target with target[1:0] != 0
- illegal_o  out  1  registered pulse: funct3 010 or 011 on a conditional branch
- br_count_o  out  CNT_W  number of accepted branches and jumps
- taken_count_o  out  CNT_W  number of redirects issued

Behaviour:
- Reset (async assert, synchronous release):
  - State = IDLE.
  - All registered outputs, redirect_pc_o and both counters = 0.
  - Reset mid-operation drops redirect_valid_o and flush_o immediately.
- Accept: in IDLE, a cycle with br_valid_i=1 or br_jump_i=1 is accepted. br_count_o increments by 1 the next cycle and wraps from 2^CNT_W-1 to 0.
- In any state other than IDLE, br_valid_i and br_jump_i are ignored and no count is recorded. Upstream holds its branch because stall_o is high.
- Taken decode, for conditional branches:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: less
  - 101 BGE: !less
  - 110 BLTU: less
  - 111 BGEU: !less
  - 010 or 011: not taken, and illegal_o pulses at T+1.
  - br_jump_i=1 forces taken and suppresses illegal_o.
- Taken with br_target_i[1:0] != 0: misalign_o pulses at T+1. No redirect is issued and the state stays IDLE.
- Taken and aligned, accepted in cycle T:
  - At T+1: state = REDIRECT, redirect_valid_o=1, redirect_pc_o=target, br_taken_o pulses, taken_count_o increments (wraps).
- State machine:
  - IDLE -> REDIRECT on a taken, aligned accept.
  - REDIRECT: hold redirect_valid_o and redirect_pc_o until redirect_ready_i=1. On the ready cycle, go to FLUSH with counter = FLUSH_CYCLES-1.
  - FLUSH: redirect_valid_o=0. Counter decrements each cycle; when counter==0, go to IDLE next cycle.
- Timing with ready in T+1: REDIRECT at T+1, FLUSH at T+2..T+1+FLUSH_CYCLES, IDLE at T+2+FLUSH_CYCLES.
- flush_o = stall_o = (state != IDLE).
- A not-taken branch changes no state. Back-to-back not-taken branches are accepted every cycle.
- br_unsigned_o is purely combinational and valid in every state.

Test Plan:
- Reset: rst_ni=0 mid-REDIRECT -> redirect_valid_o, flush_o, counters all 0 immediately; state IDLE after release.
- BEQ taken: funct3=000, eq=1, target=0x0000_0100, ready held 1 -> redirect_valid_o at T+1 with pc 0x100; flush_o high T+1..T+3 (FLUSH_CYCLES=2); taken_count_o=1, br_count_o=1.
- Ready backpressure: BLTU taken, ready=0 for 3 cycles then 1 -> redirect_pc_o stable for 4 cycles; br_valid_i pulses during this window are ignored and br_count_o stays 1; br_unsigned_o=1.
- Not-taken stream: 4 consecutive BNE with eq=1 -> no redirect, flush_o=0 throughout, br_count_o=4, taken_count_o=0.
- Exceptions: funct3=010 -> illegal_o pulse, no redirect. JAL to target 0x0000_0102 -> misalign_o pulse, no redirect, br_count_o incremented.
- Wrap: CNT_W=4, 16 taken JALs -> taken_count_o returns to 0.
